traffic_conflict_monitor: RTL and testbench
===========================================

Name: traffic_conflict_monitor

Overview:
- Independent safety checker on the far end of the six lamp-drive signals of the two-approach traffic light controller.
- Decodes both approaches every clk and checks lamp validity, approach conflicts, phase sequence, minimum yellow and maximum green dwell.
- On any violation it latches a fault code and drives a flash request to the lamp power stage.
- Fault clears only by operator clear_fault or reset.

Parameters:
- MIN_YELLOW, 5, minimum legal yellow dwell in clk cycles.
- MAX_GREEN, 31, maximum legal green dwell in clk cycles.
- FLASH_HALF, 500000, clk cycles per half-period of flash_out (0.5 s at 1 MHz).

Ports:
- clk  in  1  1 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- r1, y1, g1  in  1 each  approach 1 lamp drives
- r2, y2, g2  in  1 each  approach 2 lamp drives
- clear_fault  in  1  synchronous single-cycle operator clear
- fault  out  1  latched fault flag
- fault_code  out  3  0 NONE, 1 LAMP_INVALID, 2 CONFLICT, 3 SEQUENCE, 4 SHORT_YELLOW, 5 STUCK_GREEN
- flash_out  out  1  flash drive; toggles only while faulted

Behaviour:
- Reset values: state ARMING, fault 0, fault_code 0, flash_out 0, dwell counters 0, flash counter 0.
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Per-approach decode: {r,y,g} one-hot gives RED/YELLOW/GREEN; any other pattern is INVALID.
- Dwell counter per approach:
  - Loads 1 on a colour change.
  - Otherwise increments, saturating at MAX_GREEN+1.
  - Width is $clog2(MAX_GREEN+2).
- Per-approach partial flag: set on entry to MONITOR, cleared at that approach's first colour change.
- ARMING:
  - No checks.
  - Moves to MONITOR on the first edge sampling both approaches valid with at least one RED.
  - Dwell loads 1 on that edge.
- MONITOR checks, evaluated every edge:
  - LAMP_INVALID: either approach INVALID.
  - CONFLICT: neither approach RED.
  - SEQUENCE: colour change other than RED→GREEN, GREEN→YELLOW, YELLOW→RED.
  - SHORT_YELLOW: YELLOW→RED with yellow dwell < MIN_YELLOW and partial=0.
  - STUCK_GREEN: GREEN sampled while dwell already equals MAX_GREEN, i.e. the (MAX_GREEN+1)th green cycle.
- Fault entry:
  - Simultaneous violations report the lowest code: 1 > 2 > 3 > 4 > 5.
  - fault and fault_code update on the same edge that samples the violation; state goes to FAULT.
- FAULT:
  - fault_code is held; later violations are ignored.
  - flash_out toggles every FLASH_HALF cycles, first toggle FLASH_HALF cycles after entry.
- Clear rules:
  - clear_fault in FAULT with both approaches valid and at least one RED: next edge sets fault=0, fault_code=0, flash_out=0, state ARMING.
  - Otherwise the clear request is dropped and must be re-issued.
  - clear_fault outside FAULT has no effect.
- Reset mid-FAULT returns immediately to reset values.
- Controller compatibility: yellow lasts 5 cycles, green 30 (31 after reset), all-red never occurs, so a healthy controller never faults with the defaults.

Optional Feature:
- Macro: TRAFFIC_MON_FAULT_COUNT_EN.
- Defined:
  - Adds output fault_count [7:0].
  - Increments on each ARMING/MONITOR→FAULT entry, saturating at 255.
  - Reset to 0 by reset_n only; clear_fault does not affect it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package traffic_pkg holds:
  - lamp_t, a packed struct {r,y,g}.
  - colour_e enum: RED, YELLOW, GREEN, INVALID.
  - fault_code_e enum, values as listed under Ports.
  - mon_state_e enum: ARMING, MONITOR, FAULT.
- Sub-module lamp_phase_tracker, instantiated once per approach, contains:
  - Decode logic.
  - Previous-colour register.
  - Dwell counter and partial flag.
  - Outputs: colour, prev_colour, changed, dwell.
- Top level holds the checks, priority encoding, state machine and flash counter.

Test Plan:
- Healthy controller, FLASH_HALF=4, 4 full cycles → fault=0, fault_code=0, flash_out=0 throughout.
- Drive r1=0,g1=1,r2=0,g2=1 for one cycle → fault=1, fault_code=2 on that edge; flash_out rises 4 cycles later and toggles every 4.
- Approach 1 GREEN→YELLOW, YELLOW held 3 cycles, then RED → fault_code=4 on the RED sample; a repeat with YELLOW held 5 cycles gives no fault.
- Approach 2 GREEN held 32 cycles from a RED→GREEN transition → fault_code=5 on the 32nd green edge.
- r1=g1=1 with r2=0,g2=1 (invalid plus conflict) → fault_code=1.
- In FAULT, clear_fault while lamps conflict → fault stays 1; clear_fault with legal lamps → fault=0, ARMING, then MONITOR next edge; reset_n low mid-FAULT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic lamp conflict monitor: lamp bundle, decoded colour,
// fault codes and monitor states, plus the lamp decode and legal-step helpers.
package traffic_pkg;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamp_t;

    typedef enum logic [1:0] {RED, YELLOW, GREEN, INVALID} colour_e;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_LAMP_INVALID = 3'd1,
        FC_CONFLICT     = 3'd2,
        FC_SEQUENCE     = 3'd3,
        FC_SHORT_YELLOW = 3'd4,
        FC_STUCK_GREEN  = 3'd5
    } fault_code_e;

    typedef enum logic [1:0] {ARMING, MONITOR, FAULT} mon_state_e;

    function automatic colour_e decode_lamp(input lamp_t lamp);
        case ({lamp.r, lamp.y, lamp.g})
            3'b100:  decode_lamp = RED;
            3'b010:  decode_lamp = YELLOW;
            3'b001:  decode_lamp = GREEN;
            default: decode_lamp = INVALID;
        endcase
    endfunction

    // Only the forward cycle RED -> GREEN -> YELLOW -> RED is a legal change.
    function automatic logic legal_step(input colour_e prev, input colour_e cur);
        legal_step = (prev == RED    && cur == GREEN)  ||
                     (prev == GREEN  && cur == YELLOW) ||
                     (prev == YELLOW && cur == RED);
    endfunction

endpackage

// File: rtl/lamp_phase_tracker.sv
// Per-approach lamp tracker: decodes the lamp drives, remembers the previous colour,
// and counts how many edges the current colour has been sampled (saturating).
module lamp_phase_tracker
    import traffic_pkg::*;
#(
    parameter int MAX_GREEN = 31,
    parameter int DW        = $clog2(MAX_GREEN + 2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  lamp_t         lamp,
    input  logic          arm_load,
    input  logic          monitor,
    output colour_e       colour,
    output colour_e       prev_colour,
    output logic          changed,
    output logic [DW-1:0] dwell,
    output logic          partial
);

    colour_e       prev_reg;
    logic [DW-1:0] dwell_reg;
    logic [DW-1:0] dwell_next;
    logic          partial_reg;

    assign colour      = decode_lamp(lamp);
    assign changed     = (colour != prev_reg);
    assign prev_colour = prev_reg;
    assign dwell       = dwell_reg;
    assign partial     = partial_reg;

    always_comb begin
        dwell_next = dwell_reg;
        if (arm_load || changed) begin
            dwell_next = DW'(1);
        end else if (dwell_reg != DW'(MAX_GREEN + 1)) begin
            dwell_next = dwell_reg + DW'(1);
        end
    end

    // partial marks a phase already under way when monitoring began, so its
    // length cannot be judged until the first observed change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg    <= INVALID;
            dwell_reg   <= '0;
            partial_reg <= 1'b0;
        end else begin
            prev_reg  <= colour;
            dwell_reg <= dwell_next;
            if (arm_load) begin
                partial_reg <= 1'b1;
            end else if (monitor && changed) begin
                partial_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the two-approach lamp drives: checks, priority encoder, fault FSM
// and flash generator. Define TRAFFIC_MON_FAULT_COUNT_EN to add the fault_count output.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 5,
    parameter int MAX_GREEN  = 31,
    parameter int FLASH_HALF = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       r1,
    input  logic       y1,
    input  logic       g1,
    input  logic       r2,
    input  logic       y2,
    input  logic       g2,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_out
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam int DW = $clog2(MAX_GREEN + 2);
    localparam int FW = $clog2(FLASH_HALF + 1);

    lamp_t         lamp         [2];
    colour_e       colour       [2];
    colour_e       prev_colour  [2];
    logic          changed      [2];
    logic [DW-1:0] dwell        [2];
    logic          partial      [2];
    logic          seq_bad      [2];
    logic          short_yellow [2];
    logic          stuck_green  [2];

    mon_state_e    state_reg, state_next;
    fault_code_e   code_reg, code_next, viol_code;
    logic          flash_reg, flash_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic          lamps_invalid, no_red, lamps_ok, arm_load, monitor;

    assign lamp[0] = {r1, y1, g1};
    assign lamp[1] = {r2, y2, g2};

    assign lamps_invalid = (colour[0] == INVALID) || (colour[1] == INVALID);
    assign no_red        = (colour[0] != RED) && (colour[1] != RED);
    assign lamps_ok      = !lamps_invalid && !no_red;
    assign arm_load      = (state_reg == ARMING) && lamps_ok;
    assign monitor       = (state_reg == MONITOR);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_app
            lamp_phase_tracker #(
                .MAX_GREEN (MAX_GREEN),
                .DW        (DW)
            ) u_tracker (
                .clk         (clk),
                .reset_n     (reset_n),
                .lamp        (lamp[gi]),
                .arm_load    (arm_load),
                .monitor     (monitor),
                .colour      (colour[gi]),
                .prev_colour (prev_colour[gi]),
                .changed     (changed[gi]),
                .dwell       (dwell[gi]),
                .partial     (partial[gi])
            );

            assign seq_bad[gi]      = changed[gi] && !legal_step(prev_colour[gi], colour[gi]);
            assign short_yellow[gi] = changed[gi] && prev_colour[gi] == YELLOW && colour[gi] == RED
                                      && dwell[gi] < DW'(MIN_YELLOW) && !partial[gi];
            // dwell still holds the previous count, so equality means this is one green too many.
            assign stuck_green[gi]  = !changed[gi] && colour[gi] == GREEN && dwell[gi] == DW'(MAX_GREEN);
        end
    endgenerate

    always_comb begin
        viol_code = FC_NONE;
        if (lamps_invalid) begin
            viol_code = FC_LAMP_INVALID;
        end else if (no_red) begin
            viol_code = FC_CONFLICT;
        end else if (seq_bad[0] || seq_bad[1]) begin
            viol_code = FC_SEQUENCE;
        end else if (short_yellow[0] || short_yellow[1]) begin
            viol_code = FC_SHORT_YELLOW;
        end else if (stuck_green[0] || stuck_green[1]) begin
            viol_code = FC_STUCK_GREEN;
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        flash_next = flash_reg;
        fcnt_next  = fcnt_reg;
        case (state_reg)
            ARMING: begin
                if (lamps_ok) begin
                    state_next = MONITOR;
                end
            end
            MONITOR: begin
                if (viol_code != FC_NONE) begin
                    state_next = FAULT;
                    code_next  = viol_code;
                    fcnt_next  = '0;
                end
            end
            FAULT: begin
                // A clear is honoured only when the lamps it would release are safe.
                if (clear_fault && lamps_ok) begin
                    state_next = ARMING;
                    code_next  = FC_NONE;
                    flash_next = 1'b0;
                    fcnt_next  = '0;
                end else if (fcnt_reg == FW'(FLASH_HALF - 1)) begin
                    fcnt_next  = '0;
                    flash_next = !flash_reg;
                end else begin
                    fcnt_next = fcnt_reg + FW'(1);
                end
            end
            default: begin
                state_next = ARMING;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ARMING;
            code_reg  <= FC_NONE;
            flash_reg <= 1'b0;
            fcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            flash_reg <= flash_next;
            fcnt_reg  <= fcnt_next;
        end
    end

    assign fault      = (state_reg == FAULT);
    assign fault_code = code_reg;
    assign flash_out  = flash_reg;

`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    logic [7:0] fault_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_count_reg <= '0;
        end else if (state_reg != FAULT && state_next == FAULT && fault_count_reg != 8'hFF) begin
            fault_count_reg <= fault_count_reg + 8'd1;
        end
    end

    assign fault_count = fault_count_reg;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: a rule-level model predicts outputs per
// edge, a separate monitor pops and compares. Honours TRAFFIC_MON_FAULT_COUNT_EN.
module tb_traffic_conflict_monitor;

    localparam int FH = 4;
    localparam int MG = 31;
    localparam int MY = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       r1 = 0, y1 = 0, g1 = 0, r2 = 0, y2 = 0, g2 = 0;
    logic       clear_fault = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_out;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    always #5 clk = !clk;

    traffic_conflict_monitor #(
        .MIN_YELLOW (MY),
        .MAX_GREEN  (MG),
        .FLASH_HALF (FH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .r1          (r1),
        .y1          (y1),
        .g1          (g1),
        .r2          (r2),
        .y2          (y2),
        .g2          (g2),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .flash_out   (flash_out)
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
        ,
        .fault_count (fault_count)
`endif
    );

    typedef struct {
        logic [5:0] lamps;
        bit         clr;
        bit         f;
        int         code;
        bit         fl;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;

    // Reference model: 0 arming, 1 monitoring, 2 faulted; colours 0 red 1 yellow 2 green 3 invalid.
    int m_state, m_code, m_fcnt, m_fcount;
    bit m_flash;
    int m_prev[2];
    int m_run[2];
    bit m_part[2];

    int gph, gleft;
    bit rand_dur;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec(input bit r, input bit y, input bit g);
        case ({r, y, g})
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit fwd(input int p, input int c);
        return (p == 0 && c == 2) || (p == 2 && c == 1) || (p == 1 && c == 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_code = 0; m_fcnt = 0; m_flash = 0; m_fcount = 0;
        for (int a = 0; a < 2; a++) begin
            m_prev[a] = 3; m_run[a] = 0; m_part[a] = 0;
        end
    endtask

    task automatic model_step(input logic [5:0] l, input bit clr);
        int  c[2];
        int  viol;
        bit  legal, arm, was_mon, any_seq, any_short, any_stuck;
        c[0] = dec(l[5], l[4], l[3]);
        c[1] = dec(l[2], l[1], l[0]);
        legal = c[0] != 3 && c[1] != 3 && (c[0] == 0 || c[1] == 0);
        arm = 0;
        was_mon = (m_state == 1);
        any_seq = 0; any_short = 0; any_stuck = 0;
        for (int a = 0; a < 2; a++) begin
            if (c[a] != m_prev[a] && !fwd(m_prev[a], c[a])) any_seq = 1;
            if (m_prev[a] == 1 && c[a] == 0 && m_run[a] < MY && !m_part[a]) any_short = 1;
            if (c[a] == 2 && m_prev[a] == 2 && m_run[a] == MG) any_stuck = 1;
        end
        if (m_state == 2) begin
            if (clr && legal) begin
                m_state = 0; m_code = 0; m_flash = 0; m_fcnt = 0;
            end else begin
                m_fcnt++;
                if (m_fcnt == FH) begin
                    m_flash = !m_flash;
                    m_fcnt = 0;
                end
            end
        end else if (m_state == 0) begin
            if (legal) begin
                m_state = 1;
                arm = 1;
            end
        end else begin
            viol = 0;
            if (c[0] == 3 || c[1] == 3) viol = 1;
            else if (c[0] != 0 && c[1] != 0) viol = 2;
            else if (any_seq) viol = 3;
            else if (any_short) viol = 4;
            else if (any_stuck) viol = 5;
            if (viol != 0) begin
                m_state = 2; m_code = viol; m_fcnt = 0;
                if (m_fcount < 255) m_fcount++;
            end
        end
        for (int a = 0; a < 2; a++) begin
            if (arm || c[a] != m_prev[a]) m_run[a] = 1;
            else if (m_run[a] < MG + 1) m_run[a]++;
            if (arm) m_part[a] = 1;
            else if (was_mon && c[a] != m_prev[a]) m_part[a] = 0;
            m_prev[a] = c[a];
        end
    endtask

    // Called at a falling edge: drive, predict the next rising edge, wait one cycle.
    task automatic cycle(input logic [5:0] l, input bit clr);
        exp_t e;
        {r1, y1, g1, r2, y2, g2} = l;
        clear_fault = clr;
        model_step(l, clr);
        e.lamps = l; e.clr = clr; e.f = (m_state == 2);
        e.code = m_code; e.fl = m_flash; e.cnt = m_fcount;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_fault", fault, 0);
        check("async_rst_code", fault_code, 0);
        check("async_rst_flash", flash_out, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic int phase_len(input int ph);
        if (rand_dur) return (ph % 2 == 0) ? int'($urandom_range(28, 33)) : int'($urandom_range(3, 6));
        return (ph % 2 == 0) ? 30 : 5;
    endfunction

    task automatic gen_reset();
        gph = 0;
        gleft = phase_len(0);
    endtask

    task automatic gen_next(output logic [5:0] l);
        case (gph)
            0:       l = 6'b001_100;
            1:       l = 6'b010_100;
            2:       l = 6'b100_001;
            default: l = 6'b100_010;
        endcase
        gleft--;
        if (gleft <= 0) begin
            gph = (gph + 1) % 4;
            gleft = phase_len(gph);
        end
    endtask

    task automatic run_healthy(input int n);
        logic [5:0] l;
        for (int i = 0; i < n; i++) begin
            gen_next(l);
            cycle(l, 1'b0);
        end
    endtask

    initial begin : monitor_proc
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                $display("txn %0d lamps=%b clr=%0d exp fault=%0d code=%0d flash=%0d got fault=%0d code=%0d flash=%0d",
                         txn, e.lamps, e.clr, e.f, e.code, e.fl, fault, fault_code, flash_out);
                check("fault", fault, e.f);
                check("fault_code", fault_code, e.code);
                check("flash_out", flash_out, e.fl);
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
                check("fault_count", fault_count, e.cnt);
`endif
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin : stimulus
        logic [5:0] l;
        rand_dur = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_fault", fault, 0);
        check("reset_code", fault_code, 0);
        check("reset_flash", flash_out, 0);
        reset_n = 1'b1;

        // Healthy controller, four full cycles.
        gen_reset();
        run_healthy(280);

        // Conflict, flashing, refused clear, accepted clear, rearm.
        cycle(6'b001_001, 1'b0);
        for (int i = 0; i < 9; i++) cycle(6'b001_001, 1'b0);
        cycle(6'b001_001, 1'b1);
        cycle(6'b001_100, 1'b1);
        gen_reset();
        run_healthy(70);

        // Short yellow on approach 1, then a full-length yellow.
        do_reset();
        gen_reset();
        run_healthy(30);
        for (int i = 0; i < 3; i++) cycle(6'b010_100, 1'b0);
        cycle(6'b100_100, 1'b0);
        cycle(6'b100_100, 1'b0);
        do_reset();
        gen_reset();
        run_healthy(80);

        // Approach 2 green held 32 cycles.
        do_reset();
        gen_reset();
        run_healthy(35);
        for (int i = 0; i < 32; i++) cycle(6'b100_001, 1'b0);
        cycle(6'b100_001, 1'b0);

        // Invalid lamp plus conflict, then reset while flashing.
        do_reset();
        gen_reset();
        run_healthy(5);
        cycle(6'b101_001, 1'b0);
        for (int i = 0; i < 6; i++) cycle(6'b101_001, 1'b0);
        do_reset();

        // Randomised phase lengths, glitches and operator clears.
        rand_dur = 1;
        gen_reset();
        for (int i = 0; i < 2000; i++) begin
            gen_next(l);
            if ($urandom_range(0, 63) == 0) l = 6'($urandom);
            cycle(l, $urandom_range(0, 15) == 0);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
